aprox_arbiter: RTL and testbench
================================

APROX_ARBITER -- requirements
Module: aprox_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one aprox unit (2..8).
REQ-002 Parameter W, default 32, SHALL set the datapath width; data is signed Q16.16.
REQ-003 Parameter LAT, default 1, SHALL set the cycles from driving ap_in to ap_out being valid (1..7).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  input  NREQ  SHALL carry the per-requester request level.
REQ-007 req_data  input  NREQ*W  SHALL carry the signed operands, requester i in bits [i*W +: W].
REQ-008 gnt  output  NREQ  SHALL be a registered one-hot, one-cycle acceptance pulse.
REQ-009 ap_in  output  W  SHALL be the registered operand driven into the shared aprox unit.
REQ-010 ap_out  input  W  SHALL be the signed result returned by the shared aprox unit.
REQ-011 rsp_valid  output  NREQ  SHALL be the registered one-hot result-valid flag for the owning requester.
REQ-012 rsp_data  output  W  SHALL be the registered result, meaningful only while rsp_valid is nonzero.
REQ-013 rsp_ready  input  NREQ  SHALL be the per-requester result acceptance signal.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, WAIT and RESP.
REQ-016 In IDLE with any req bit set, the arbiter SHALL select the first set bit scanning round-robin from ptr+1 (mod NREQ).
REQ-017 On that edge it SHALL set gnt[sel]=1, ap_in=req_data[sel], owner=sel, ptr=sel, cnt=LAT, and go to WAIT.
REQ-018 gnt SHALL return to 0 on the following edge, so it is high for exactly one cycle per accepted request.
REQ-019 In WAIT, cnt SHALL decrement each edge; on the edge where cnt==1, rsp_data SHALL capture ap_out, rsp_valid[owner] SHALL set, and the state SHALL go to RESP.
REQ-020 Latency SHALL be LAT+1 edges, from the edge that samples req to rsp_valid being visible.
REQ-021 In RESP, rsp_valid and rsp_data SHALL hold stable until rsp_ready[owner]==1 on an edge; that edge SHALL clear rsp_valid and return to IDLE.
REQ-022 rsp_ready bits of non-owners SHALL be ignored.
REQ-023 req SHALL be ignored in WAIT and RESP; no gnt is issued there.
REQ-024 The minimum issue interval SHALL be LAT+2 cycles, because one IDLE cycle is always taken between operations.
REQ-025 A requester SHALL hold req and req_data until it sees gnt.
REQ-026 A req still high in a later IDLE cycle SHALL be treated as a new request.
REQ-027 Data SHALL pass unmodified in both directions: no saturation, sign change or rounding.
REQ-028 If several req bits are set simultaneously, exactly one SHALL be granted per operation.
REQ-029 No requester SHALL wait more than NREQ-1 other grants while its req stays high.
REQ-030 ap_in SHALL hold its value from grant until the next grant.

Reset
REQ-031 While rst_n==0, asynchronously: state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, ap_in=0, cnt=0, owner=0, ptr=NREQ-1, busy=0.
REQ-032 With ptr=NREQ-1 after reset, requester 0 SHALL have highest priority on the first arbitration.
REQ-033 A reset asserted in WAIT or RESP SHALL abort the operation and discard the result; no rsp_valid appears after release.
REQ-034 The first edge after rst_n rises SHALL already perform arbitration if any req is high.

Verification
REQ-035 Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, rsp_valid=0, rsp_data=0, ap_in=0, busy=0 throughout.
REQ-036 LAT=1, only req[2]=1, data 131072, rsp_ready=4'b1111:
- edge0 -> gnt=4'b0100 and ap_in=131072;
- edge1 -> rsp_valid=4'b0100 and rsp_data=model(131072);
- edge2 -> IDLE.
REQ-037 All four req high, data {1, 65534, 131073, 2147418112}, each requester drops req on gnt -> grant order 0,1,2,3, each rsp_data=model(operand). Then re-raise req0 and req3 -> next grant 0, then 3.
REQ-038 Backpressure: rsp_ready[owner]=0 for 5 cycles with req[1]=1 pending -> rsp_valid and rsp_data stable, gnt=0. Raising rsp_ready[owner] -> released, then req1 granted after one IDLE cycle.
REQ-039 Non-owner ready: rsp_ready=4'b1110 while owner=0 -> RESP held; rsp_ready[0]=1 -> released.
REQ-040 Reset abort, LAT=3: drop rst_n during WAIT -> outputs zero immediately. After release with req=4'b1000 -> gnt=4'b1000 on the first edge, rsp_valid on the 4th edge.

Source files
------------

// File: rtl/aprox_arbiter.sv
// Round-robin arbiter sharing one fixed-latency aprox unit between NREQ requesters.
// One operation is in flight at a time: grant, wait LAT cycles, hold the result until accepted.
module aprox_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      ap_in,
    input  logic [W-1:0]      ap_out,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   idx;
    logic            found;
    logic [2:0]      cnt;
    logic [W-1:0]    data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*W +: W];
    end

    // Round-robin pick: first set req bit scanning upward from ptr+1, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Result handshake: a result transfers on an edge where rsp_valid[owner] and
    // rsp_ready[owner] are both high; other rsp_ready bits have no effect.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = WAIT;
            WAIT:    if (cnt == 3'd1) state_nx = RESP;
            RESP:    if (rsp_ready[owner]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            ap_in     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            cnt       <= '0;
            owner     <= '0;
            ptr       <= PW'(NREQ - 1);
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << sel;
                        ap_in <= data_arr[sel];
                        owner <= sel;
                        ptr   <= sel;
                        cnt   <= 3'(LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rsp_data  <= ap_out;
                        rsp_valid <= NREQ'(1) << owner;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aprox_arbiter.sv
// Bench for aprox_arbiter: LAT=1 instance against a transaction-level reference,
// plus a LAT=3 instance for reset abort and latency.
module tb_aprox_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LAT=1 instance
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      ap_in;
    logic [W-1:0]      ap_out;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [NREQ-1:0]   rsp_ready;
    logic              busy;
    logic [1:0]        dbg_state;

    // LAT=3 instance
    logic              rst3_n;
    logic [NREQ-1:0]   req3;
    logic [NREQ*W-1:0] req_data3;
    logic [NREQ-1:0]   gnt3;
    logic [W-1:0]      ap_in3;
    logic [W-1:0]      ap_out3;
    logic [NREQ-1:0]   rsp_valid3;
    logic [W-1:0]      rsp_data3;
    logic [NREQ-1:0]   rsp_ready3;
    logic              busy3;
    logic [1:0]        dbg_state3;
    logic [W-1:0]      p3_a;
    logic [W-1:0]      p3_b;

    // Stand-in aprox unit: x/2 + 0.5 in Q16.16.
    function automatic logic [W-1:0] aprox_f(input logic [W-1:0] x);
        logic signed [W-1:0] s;
        s = $signed(x) >>> 1;
        return s + 32'sd32768;
    endfunction

    assign ap_out = aprox_f(ap_in);

    always @(posedge clk) begin
        p3_a <= aprox_f(ap_in3);
        p3_b <= p3_a;
    end
    assign ap_out3 = p3_b;

    aprox_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .ap_in     (ap_in),
        .ap_out    (ap_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    aprox_arbiter #(.NREQ(NREQ), .W(W), .LAT(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .req       (req3),
        .req_data  (req_data3),
        .gnt       (gnt3),
        .ap_in     (ap_in3),
        .ap_out    (ap_out3),
        .rsp_valid (rsp_valid3),
        .rsp_data  (rsp_data3),
        .rsp_ready (rsp_ready3),
        .busy      (busy3),
        .dbg_state (dbg_state3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: one operation in flight, timed by edge numbers.
    bit           m_active;
    int           m_owner;
    int           m_last;
    int           m_gedge;
    int           edge_n;
    logic [W-1:0] m_op;
    logic [W-1:0] exp_q[$];
    int           gnt_log[$];

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = NREQ - 1;
        exp_q.delete();
    endtask

    task automatic set_op(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    // One clock of the LAT=1 instance: sample driven inputs, advance model, compare.
    task automatic step();
        logic [NREQ-1:0]   r;
        logic [NREQ-1:0]   y;
        logic [NREQ*W-1:0] d;
        logic [NREQ-1:0]   e_gnt;
        logic [NREQ-1:0]   e_vld;
        r = req;
        y = rsp_ready;
        d = req_data;
        @(posedge clk);
        #1;
        edge_n++;
        e_gnt = '0;
        e_vld = '0;
        if (!m_active) begin
            if (r != '0) begin
                m_owner  = rr_pick(r, m_last);
                m_last   = m_owner;
                m_active = 1'b1;
                m_gedge  = edge_n;
                m_op     = d[m_owner*W +: W];
                exp_q.push_back(aprox_f(m_op));
                e_gnt[m_owner] = 1'b1;
            end
        end else if (edge_n > m_gedge + LAT1 && y[m_owner]) begin
            m_active = 1'b0;
            void'(exp_q.pop_front());
        end
        if (m_active && edge_n >= m_gedge + LAT1) e_vld[m_owner] = 1'b1;
        check("gnt", gnt, e_gnt);
        check("rsp_valid", rsp_valid, e_vld);
        check("busy", busy, m_active);
        if (m_active) check("ap_in", ap_in, m_op);
        if (e_vld != '0) check("rsp_data", rsp_data, exp_q[0]);
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
        req = req & ~gnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] op0;
        rst_n      = 1'b1;
        rst3_n     = 1'b0;
        req        = '0;
        req_data   = '0;
        rsp_ready  = '1;
        req3       = '0;
        req_data3  = '0;
        rsp_ready3 = '1;
        edge_n     = 0;
        model_reset();
        #1;
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom);

        // Held reset with all requests high
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_gnt", gnt, 4'b0000);
            check("rst_rsp_valid", rsp_valid, 4'b0000);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_ap_in", ap_in, 0);
            check("rst_busy", busy, 1'b0);
        end
        req   = '0;
        rst_n = 1'b1;
        step();

        // Single requester 2, LAT=1
        req = 4'b0100;
        set_op(2, 32'd131072);
        step();
        check("t36_gnt", gnt, 4'b0100);
        check("t36_ap_in", ap_in, 32'd131072);
        step();
        check("t36_rsp_valid", rsp_valid, 4'b0100);
        check("t36_rsp_data", rsp_data, 32'd98304);
        step();
        check("t36_idle", busy, 1'b0);

        // Reset asserted mid-operation aborts it
        req = 4'b0001;
        set_op(0, 32'h0001_2345);
        step();
        rst_n = 1'b0;
        #1;
        check("abort_gnt", gnt, 4'b0000);
        check("abort_ap_in", ap_in, 0);
        check("abort_busy", busy, 1'b0);
        model_reset();
        req = 4'b1111;
        set_op(0, 32'd1);
        set_op(1, 32'd65534);
        set_op(2, 32'd131073);
        set_op(3, 32'd2147418112);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt_log.delete();

        // All four request; each drops on its grant
        step();
        check("t34_first_edge_gnt", gnt, 4'b0001);
        for (int c = 0; c < 11; c++) step();
        check("t37_ngrants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_log.size()) check("t37_order", gnt_log[i], i);
        end
        gnt_log.delete();
        req = 4'b1001;
        set_op(0, 32'hFFFF_0000);
        set_op(3, 32'h8000_0000);
        for (int c = 0; c < 6; c++) step();
        check("t37b_ngrants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t37b_first", gnt_log[0], 0);
            check("t37b_second", gnt_log[1], 3);
        end

        // Backpressure on owner 0 with non-owner ready high, req1 pending
        op0 = 32'h0003_8000;
        rsp_ready = 4'b1110;
        req = 4'b0001;
        set_op(0, op0);
        step();
        req[1] = 1'b1;
        set_op(1, 32'hFFFE_C000);
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            check("t38_hold_valid", rsp_valid, 4'b0001);
            check("t38_hold_data", rsp_data, aprox_f(op0));
            check("t38_no_gnt", gnt, 4'b0000);
        end
        rsp_ready = 4'b1111;
        step();
        check("t38_release", rsp_valid, 4'b0000);
        step();
        check("t38_req1_gnt", gnt, 4'b0010);
        step();
        step();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_op(i, $urandom);
                end
            end
            rsp_ready = NREQ'($urandom_range(0, 15));
            step();
        end
        req = '0;
        rsp_ready = '1;
        for (int c = 0; c < 4; c++) step();

        // LAT=3: abort in WAIT, then fresh request from requester 3
        @(posedge clk);
        #1;
        req3 = 4'b0001;
        req_data3[0 +: W] = 32'h0007_0000;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        check("l3_gnt0", gnt3, 4'b0001);
        req3 = '0;
        @(posedge clk);
        #1;
        check("l3_busy_wait", busy3, 1'b1);
        rst3_n = 1'b0;
        #1;
        check("l3_abort_gnt", gnt3, 4'b0000);
        check("l3_abort_vld", rsp_valid3, 4'b0000);
        check("l3_abort_data", rsp_data3, 0);
        check("l3_abort_ap_in", ap_in3, 0);
        check("l3_abort_busy", busy3, 1'b0);
        req3 = 4'b1000;
        req_data3[3*W +: W] = 32'hFFF1_2340;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        check("l3_gnt3", gnt3, 4'b1000);
        check("l3_ap_in", ap_in3, 32'hFFF1_2340);
        req3 = '0;
        for (int c = 2; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check("l3_no_vld", rsp_valid3, 4'b0000);
        end
        @(posedge clk);
        #1;
        check("l3_vld_edge4", rsp_valid3, 4'b1000);
        check("l3_data", rsp_data3, aprox_f(32'hFFF1_2340));
        @(posedge clk);
        #1;
        check("l3_release", rsp_valid3, 4'b0000);
        check("l3_idle", busy3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
